// File: rtl/a1_pkg.sv
// Shared timing-chain definitions for the FS scaler stages.
`timescale 1ns/1ps
package a1_pkg;

  localparam logic FS_RESET = 1'b0;

  typedef struct packed {
    logic fs;
    logic pa;
    logic pb;
  } stage_out_t;

  // Pulse decode is gated by the stage clock level so the outputs cannot glitch
  // when the toggle flop changes on the rising clock edge.
  function automatic stage_out_t stage_decode(input logic clk_lvl,
                                              input logic fs,
                                              input logic rst_n);
    stage_out_t o;
    o.fs = fs;
    o.pa = ~clk_lvl & fs & rst_n;
    o.pb = ~clk_lvl & ~fs & rst_n;
    return o;
  endfunction

endpackage

// File: rtl/a1_scaler_stage.sv
// Generic divide-by-two timing stage: toggle flop plus two non-overlapping pulse decoders.
`timescale 1ns/1ps
module a1_scaler_stage
  import a1_pkg::*;
(
  input  logic clk_i,
  input  logic rst_n_i,
  output logic fs_o,
  output logic pa_o,
  output logic pb_o
);

  logic       fs_q;
  logic       fs_d;
  stage_out_t dec;

  assign fs_d = ~fs_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) fs_q <= FS_RESET;
    else          fs_q <= fs_d;
  end

  assign dec  = stage_decode(clk_i, fs_q, rst_n_i);
  assign fs_o = dec.fs;
  assign pa_o = dec.pa;
  assign pb_o = dec.pb;

endmodule

// File: rtl/a1.sv
// Scaler stage A1: divides FS01_ by two, producing FS02/FS02A and decoded pulses F02A/F02B.
`timescale 1ns/1ps
module a1 (
  input  logic FS01_,
  input  logic rst,
  output logic F02A,
  output logic F02B,
  output logic FS02,
  output logic FS02A
);

  logic fs02;

  a1_scaler_stage u_stage (
    .clk_i   (FS01_),
    .rst_n_i (rst),
    .fs_o    (fs02),
    .pa_o    (F02A),
    .pb_o    (F02B)
  );

  // FS02A shares the FS02 driver so the two never skew.
  assign FS02  = fs02;
  assign FS02A = fs02;

endmodule

// File: tb/tb_a1.sv
// Randomized self-checking bench for a1 against an edge-counting reference model.
`timescale 1ns/1ps
module tb_a1;

  localparam time HALF = 4883;

  logic FS01_ = 1'b0;
  logic rst   = 1'b0;
  logic F02A, F02B, FS02, FS02A;

  int n_cmp = 0;
  int n_err = 0;

  a1 dut (
    .FS01_ (FS01_),
    .rst   (rst),
    .F02A  (F02A),
    .F02B  (F02B),
    .FS02  (FS02),
    .FS02A (FS02A)
  );

  initial forever #HALF FS01_ = ~FS01_;

  // Reference: FS02 is the parity of rising FS01_ edges seen since reset release.
  int unsigned edges = 0;
  always @(posedge FS01_ or negedge rst) begin
    if (!rst) edges = 0;
    else      edges = edges + 1;
  end

  // Side monitors for pulse width, period, counts and exclusivity.
  time ta = 0, tb_ = 0, tf = 0;
  time wa = 0, wb = 0, pf = 0;
  int  cnt_a = 0, cnt_b = 0, excl_viol = 0;
  always @(posedge F02A) begin ta = $time; cnt_a++; end
  always @(negedge F02A) wa = $time - ta;
  always @(posedge F02B) begin tb_ = $time; cnt_b++; end
  always @(negedge F02B) wb = $time - tb_;
  always @(posedge FS02) begin
    if (tf != 0) pf = $time - tf;
    tf = $time;
  end
  always @(F02A or F02B) if (F02A && F02B) excl_viol++;

  task automatic cmp(input string tag, input logic obs, input logic exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic cmp_int(input string tag, input longint obs, input longint exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic check_all(input string tag);
    logic e_fs, e_a, e_b;
    e_fs = (rst && (edges % 2 == 1)) ? 1'b1 : 1'b0;
    e_a  = (!FS01_ && e_fs && rst) ? 1'b1 : 1'b0;
    e_b  = (!FS01_ && !e_fs && rst) ? 1'b1 : 1'b0;
    cmp({tag, ".FS02"},  FS02,  e_fs);
    cmp({tag, ".FS02A"}, FS02A, e_fs);
    cmp({tag, ".F02A"},  F02A,  e_a);
    cmp({tag, ".F02B"},  F02B,  e_b);
  endtask

  initial begin
    bit found;

    // Reset hold across several FS01_ transitions.
    for (int i = 0; i < 24; i++) begin
      #500;
      cmp("hold.FS02",  FS02,  1'b0);
      cmp("hold.FS02A", FS02A, 1'b0);
      cmp("hold.F02A",  F02A,  1'b0);
      cmp("hold.F02B",  F02B,  1'b0);
    end

    // Release during an FS01_-low half: F02B must assert immediately.
    @(negedge FS01_);
    #1000 rst = 1'b1;
    #10;
    cmp("rel_low.F02B", F02B, 1'b1);
    cmp("rel_low.F02A", F02A, 1'b0);
    cmp("rel_low.FS02", FS02, 1'b0);
    @(posedge FS01_); #1;
    cmp("rel_low.first_edge", FS02, 1'b1);

    // Free run with random sample points inside each half-cycle.
    for (int i = 0; i < 100; i++) begin
      @(FS01_);
      #($urandom_range(1, int'(HALF) - 2));
      check_all("run");
    end
    cmp_int("run.F02A_width", wa, HALF);
    cmp_int("run.F02B_width", wb, HALF);
    cmp_int("run.FS02_period", pf, 4 * HALF);

    // Exactly one pulse of each kind per FS02 period over 8 periods.
    @(posedge FS01_); #1;
    cnt_a = 0; cnt_b = 0;
    repeat (16) @(posedge FS01_);
    #1;
    cmp_int("count.F02A", cnt_a, 8);
    cmp_int("count.F02B", cnt_b, 8);

    // Directed mid-run reset while FS02=1 and FS01_ low.
    found = 1'b0;
    for (int k = 0; k < 6 && !found; k++) begin
      @(negedge FS01_); #1;
      if (FS02) found = 1'b1;
    end
    cmp("midrst.found_state", found, 1'b1);
    #500 rst = 1'b0;
    #1;
    check_all("midrst.async");
    cmp("midrst.F02A_low", F02A, 1'b0);
    #3000 rst = 1'b1;
    #5;
    check_all("midrst.released_low");
    @(posedge FS01_); #1;
    cmp("midrst.first_edge", FS02, 1'b1);

    // Random reset pulses at random points within a half-cycle.
    for (int i = 0; i < 12; i++) begin
      @(FS01_);
      #($urandom_range(100, 1500));
      rst = 1'b0;
      #1;
      check_all("rndrst.asserted");
      #($urandom_range(100, 2500));
      rst = 1'b1;
      #2;
      check_all("rndrst.released");
      repeat ($urandom_range(1, 6)) begin
        @(FS01_);
        #($urandom_range(1, int'(HALF) - 2));
        check_all("rndrst.run");
      end
    end

    cmp_int("excl.F02A_and_F02B", excl_viol, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
